// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access controller and its helpers:
// load/store command codes, FSM state type and byte-lane enable constants.
package mem_pkg;

    // Load command encodings carried on MEM_READ
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    // Store command encodings carried on MEM_WRITE
    localparam logic [2:0] ST_SB  = 3'd1;
    localparam logic [2:0] ST_SH  = 3'd2;
    localparam logic [2:0] ST_SW  = 3'd3;

    // Byte-lane enables
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    function automatic logic is_load(input logic [2:0] cmd);
        return (cmd >= LD_LB) && (cmd <= LD_LHU);
    endfunction

    function automatic logic is_store(input logic [2:0] cmd);
        return (cmd >= ST_SB) && (cmd <= ST_SW);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks the byte/half selected by the byte
// offset out of a memory word and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  cmd,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection followed by extension according to the load command
    always_comb begin
        sel_byte = word[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? word[31:16] : word[15:0];
        result   = word;
        case (cmd)
            LD_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            LD_LH:   result = {{16{sel_half[15]}}, sel_half};
            LD_LBU:  result = {24'd0, sel_byte};
            LD_LHU:  result = {16'd0, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller. Runs an IDLE/ACCESS/DONE handshake
// with data memory, aligns stores into byte lanes, extracts loads and raises
// the global BUSY_WAIT stall while an access is outstanding.
// Optional build macro: MEM_TIMEOUT_EN (adds TIMEOUT_CYCLES and MEM_FAULT).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [2:0]        MEM_READ,
    input  logic [2:0]        MEM_WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic [31:0]       DATA_READED,
    output logic              BUSY_WAIT,
    output logic              MISALIGNED,
    output logic              D_MEM_READ,
    output logic              D_MEM_WRITE,
    output logic [ADDR_W-1:0] D_MEM_ADDRESS,
    output logic [31:0]       D_MEM_WRITEDATA,
    output logic [3:0]        D_MEM_BYTE_EN,
    input  logic [31:0]       D_MEM_READDATA,
    input  logic              D_MEM_BUSYWAIT
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              MEM_FAULT
`endif
);

    mem_state_t state_q, state_d;

    logic        ld_valid, st_valid, req, misaligned, go;
    logic        size_half, size_word;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic        is_load_q;
    logic [2:0]  ld_cmd_q;
    logic [1:0]  off_q;
    logic [31:0] ld_result;
    logic        timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_cnt_q;
`endif

    // Command decode: a valid load wins over any store; alignment and lane setup
    always_comb begin
        ld_valid   = is_load(MEM_READ);
        st_valid   = !ld_valid && is_store(MEM_WRITE);
        req        = ld_valid || st_valid;
        size_half  = ld_valid ? (MEM_READ == LD_LH || MEM_READ == LD_LHU) : (st_valid && MEM_WRITE == ST_SH);
        size_word  = ld_valid ? (MEM_READ == LD_LW) : (st_valid && MEM_WRITE == ST_SW);
        misaligned = (size_half && ADDRESS[0]) || (size_word && (ADDRESS[1:0] != 2'b00));
        go         = req && !misaligned;
        be_next    = BE_WORD;
        wdata_next = WRITE_DATA;
        if (!ld_valid) begin
            case (MEM_WRITE)
                ST_SB: begin
                    be_next    = BE_BYTE0 << ADDRESS[1:0];
                    wdata_next = {4{WRITE_DATA[7:0]}};
                end
                ST_SH: begin
                    be_next    = ADDRESS[1] ? BE_HALF_HI : BE_HALF_LO;
                    wdata_next = {2{WRITE_DATA[15:0]}};
                end
                default: begin
                    be_next    = BE_WORD;
                    wdata_next = WRITE_DATA;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic, memory strobes and pipeline stall
    always_comb begin
        state_d     = state_q;
        BUSY_WAIT   = 1'b0;
        D_MEM_READ  = 1'b0;
        D_MEM_WRITE = 1'b0;
        case (state_q)
            IDLE: begin
                // The stall is gated by reset so an asserted reset never
                // freezes the pipeline, even with a command still presented.
                BUSY_WAIT = go && RESET;
                if (go) state_d = ACCESS;
            end
            ACCESS: begin
                BUSY_WAIT   = 1'b1;
                D_MEM_READ  = is_load_q;
                D_MEM_WRITE = !is_load_q;
                if (!D_MEM_BUSYWAIT || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    // Busy-wait counter, only running while an access is outstanding
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                 tmo_cnt_q <= '0;
        else if (state_q == ACCESS) tmo_cnt_q <= tmo_cnt_q + TW'(1);
        else                        tmo_cnt_q <= '0;
    end

    assign timeout_hit = (state_q == ACCESS) && D_MEM_BUSYWAIT &&
                         (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    mem_load_align u_load_align (
        .word   (D_MEM_READDATA),
        .offset (off_q),
        .cmd    (ld_cmd_q),
        .result (ld_result)
    );

    // Access latching, load capture and the misalignment pulse
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            D_MEM_ADDRESS   <= '0;
            D_MEM_WRITEDATA <= '0;
            D_MEM_BYTE_EN   <= BE_NONE;
            is_load_q       <= 1'b0;
            ld_cmd_q        <= '0;
            off_q           <= '0;
            DATA_READED     <= '0;
            MISALIGNED      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            MEM_FAULT       <= 1'b0;
`endif
        end else begin
            MISALIGNED <= (state_q == IDLE) && req && misaligned;
`ifdef MEM_TIMEOUT_EN
            MEM_FAULT  <= timeout_hit;
`endif
            if (state_q == IDLE && go) begin
                D_MEM_ADDRESS   <= {ADDRESS[ADDR_W-1:2], 2'b00};
                D_MEM_WRITEDATA <= wdata_next;
                D_MEM_BYTE_EN   <= be_next;
                is_load_q       <= ld_valid;
                ld_cmd_q        <= MEM_READ;
                off_q           <= ADDRESS[1:0];
            end
            if (timeout_hit)
                DATA_READED <= '0;
            else if (state_q == ACCESS && !D_MEM_BUSYWAIT && is_load_q)
                DATA_READED <= ld_result;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// load/store traffic against a word-addressed memory model and expected
// results computed from byte-offset arithmetic.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  MEM_READ, MEM_WRITE;
    logic [31:0] ADDRESS, WRITE_DATA;
    logic [31:0] DATA_READED;
    logic        BUSY_WAIT, MISALIGNED, D_MEM_READ, D_MEM_WRITE;
    logic [31:0] D_MEM_ADDRESS, D_MEM_WRITEDATA, D_MEM_READDATA;
    logic [3:0]  D_MEM_BYTE_EN;
    logic        D_MEM_BUSYWAIT;
`ifdef MEM_TIMEOUT_EN
    logic        MEM_FAULT;
`endif

    always #5 CLK = ~CLK;

    mem_access_unit #(
        .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .MEM_READ        (MEM_READ),
        .MEM_WRITE       (MEM_WRITE),
        .ADDRESS         (ADDRESS),
        .WRITE_DATA      (WRITE_DATA),
        .DATA_READED     (DATA_READED),
        .BUSY_WAIT       (BUSY_WAIT),
        .MISALIGNED      (MISALIGNED),
        .D_MEM_READ      (D_MEM_READ),
        .D_MEM_WRITE     (D_MEM_WRITE),
        .D_MEM_ADDRESS   (D_MEM_ADDRESS),
        .D_MEM_WRITEDATA (D_MEM_WRITEDATA),
        .D_MEM_BYTE_EN   (D_MEM_BYTE_EN),
        .D_MEM_READDATA  (D_MEM_READDATA),
        .D_MEM_BUSYWAIT  (D_MEM_BUSYWAIT)
`ifdef MEM_TIMEOUT_EN
        ,
        .MEM_FAULT       (MEM_FAULT)
`endif
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_dr;
    logic [31:0] mem [int unsigned];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic get_word(input int unsigned a, output logic [31:0] w);
        if (!mem.exists(a)) mem[a] = $urandom;
        w = mem[a];
    endtask

    // Expected load result from plain shift/mask arithmetic
    function automatic logic [31:0] load_ref(input logic [2:0] rd, input logic [31:0] w, input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (rd)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One pipeline-presented command, driven and checked end to end
    task automatic txn(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int unsigned nb);
        logic        is_ld, is_st, half, wrd, mis;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wdx, w;
        int unsigned stalls, k;
        is_ld = (rd >= 3'd1) && (rd <= 3'd5);
        is_st = !is_ld && (wr >= 3'd1) && (wr <= 3'd3);
        half  = is_ld ? (rd == 3'd2 || rd == 3'd5) : (is_st && wr == 3'd2);
        wrd   = is_ld ? (rd == 3'd3) : (is_st && wr == 3'd3);
        off   = addr[1:0];
        mis   = (half && off[0]) || (wrd && off != 2'b00);
        be    = 4'hF;
        wdx   = wd;
        if (is_st && wr == 3'd1) begin be = 4'b0001 << off; wdx = {4{wd[7:0]}}; end
        if (is_st && wr == 3'd2) begin be = off[1] ? 4'b1100 : 4'b0011; wdx = {2{wd[15:0]}}; end

        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
        #1;
        if (!(is_ld || is_st) || mis) begin
            check("busy_no_access", BUSY_WAIT, 0);
            @(posedge CLK); #1;
            check("misaligned_pulse", MISALIGNED, mis);
            check("no_strobe", {D_MEM_READ, D_MEM_WRITE}, 0);
            check("dr_hold", DATA_READED, exp_dr);
            MEM_READ = 0; MEM_WRITE = 0;
            return;
        end

        stalls = 0;
        k      = 0;
        w      = 0;
        for (int g = 0; g < 200; g++) begin
            if (!BUSY_WAIT) break;
            stalls++;
            if (D_MEM_READ || D_MEM_WRITE) begin
                if (k == 0) begin
                    check("mem_addr", D_MEM_ADDRESS, addr & 32'hFFFF_FFFC);
                    check("strobes", {D_MEM_READ, D_MEM_WRITE}, {is_ld, !is_ld});
                    check("byte_en", D_MEM_BYTE_EN, be);
                    if (is_st) check("wdata", D_MEM_WRITEDATA, wdx);
                end
                get_word(addr >> 2, w);
                D_MEM_READDATA = w;
                D_MEM_BUSYWAIT = (k < nb);
                if (k == nb && is_st) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) w[8*i +: 8] = wdx[8*i +: 8];
                    mem[addr >> 2] = w;
                end
                k++;
            end else begin
                D_MEM_BUSYWAIT = 1'($urandom_range(0, 1));
            end
            @(negedge CLK); #1;
        end
        check("stall_edges", stalls, nb + 2);
        if (is_ld) exp_dr = load_ref(rd, w, off);
        check("data_readed", DATA_READED, exp_dr);
        check("done_strobes", {D_MEM_READ, D_MEM_WRITE, MISALIGNED}, 0);
        MEM_READ = 0; MEM_WRITE = 0; D_MEM_BUSYWAIT = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 0; MEM_READ = 0; MEM_WRITE = 0; ADDRESS = 0; WRITE_DATA = 0;
        D_MEM_READDATA = 0; D_MEM_BUSYWAIT = 0; exp_dr = 0;
        #12;
        check("rst_busy", BUSY_WAIT, 0);
        check("rst_dr", DATA_READED, 0);
        check("rst_dmem", {D_MEM_READ, D_MEM_WRITE, MISALIGNED, D_MEM_BYTE_EN}, 0);
        check("rst_addr", D_MEM_ADDRESS, 0);
        check("rst_wdata", D_MEM_WRITEDATA, 0);
        @(negedge CLK); RESET = 1;

        // Directed cases
        mem[32'h100 >> 2] = 32'h8011_2233;
        mem[32'h104 >> 2] = 32'hCAFE_BABE;
        txn(3'd1, 3'd0, 32'h103, 32'h0, 3);           // LB
        txn(3'd5, 3'd0, 32'h102, 32'h0, 0);           // LHU
        txn(3'd3, 3'd0, 32'h104, 32'h0, 1);           // LW
        txn(3'd0, 3'd1, 32'h201, 32'h0000_00A5, 0);   // SB
        txn(3'd3, 3'd0, 32'h102, 32'h0, 0);           // misaligned LW
        txn(3'd2, 3'd3, 32'h102, 32'h1234_5678, 0);   // LH wins over SW
        txn(3'd6, 3'd2, 32'h203, 32'h0, 0);           // misaligned SH
        txn(3'd0, 3'd5, 32'h200, 32'h0, 0);           // no command

        // Asynchronous reset in the middle of an access
        @(negedge CLK);
        MEM_READ = 3'd3; ADDRESS = 32'h104; D_MEM_BUSYWAIT = 1;
        @(negedge CLK); @(negedge CLK); #1;
        check("pre_reset_read", D_MEM_READ, 1);
        #1 RESET = 0;
        #1;
        check("mid_rst_busy", BUSY_WAIT, 0);
        check("mid_rst_read", D_MEM_READ, 0);
        check("mid_rst_dr", DATA_READED, 0);
        exp_dr = 0;
        MEM_READ = 0; D_MEM_BUSYWAIT = 0;
        @(negedge CLK); RESET = 1;
        @(negedge CLK); #1;
        check("post_rst_idle", {BUSY_WAIT, D_MEM_READ, D_MEM_WRITE}, 0);

`ifdef MEM_TIMEOUT_EN
        begin
            bit seen;
            seen = 0;
            txn(3'd3, 3'd0, 32'h104, 32'h0, 0);
            @(negedge CLK);
            MEM_READ = 3'd3; ADDRESS = 32'h108; D_MEM_BUSYWAIT = 1;
            for (int g = 0; g < 50 && !seen; g++) begin
                @(negedge CLK); #1;
                if (MEM_FAULT) begin
                    seen = 1;
                    check("fault_dr", DATA_READED, 0);
                    check("fault_busy", BUSY_WAIT, 0);
                    check("fault_strobe", D_MEM_READ, 0);
                end
            end
            check("fault_seen", seen, 1);
            MEM_READ = 0; D_MEM_BUSYWAIT = 0; exp_dr = 0;
            @(negedge CLK); #1;
            check("fault_pulse_end", MEM_FAULT, 0);
        end
`endif

        // Randomized traffic over a small window so loads revisit stored words
        for (int n = 0; n < 150; n++) begin
            logic [2:0] rd, wr;
            rd = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'd0;
            wr = 3'($urandom_range(0, 7));
            txn(rd, wr, 32'h200 + $urandom_range(0, 31), $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
